// File: rtl/sd_pkg.sv
// Shared types for the signed-digit on-the-fly conversion units.
// Digit encoding {zp, zn}, digit value helper and converter states.
package sd_pkg;

    typedef logic [1:0] sd_digit_t;

    localparam sd_digit_t SD_POS  = 2'b10;
    localparam sd_digit_t SD_NEG  = 2'b01;
    localparam sd_digit_t SD_ZERO = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } otf_state_t;

    // Both 00 and 11 encode zero.
    function automatic logic signed [1:0] sd_value(input sd_digit_t d);
        logic signed [1:0] v;
        v = 2'sd0;
        case (d)
            SD_POS:  v = 2'sd1;
            SD_NEG:  v = -2'sd1;
            default: v = 2'sd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/sd_otf_step.sv
// One on-the-fly conversion step: appends a signed digit to Q/QM.
// Ports: q, qm (current pair), d (digit) -> q_nxt, qm_nxt.
module sd_otf_step
    import sd_pkg::*;
#(
    parameter int W = 17
) (
    input  logic [W-1:0] q,
    input  logic [W-1:0] qm,
    input  sd_digit_t    d,
    output logic [W-1:0] q_nxt,
    output logic [W-1:0] qm_nxt
);

    logic pos;
    logic neg;

    assign pos = (d == SD_POS);
    assign neg = (d == SD_NEG);

    // QM tracks Q-1, so a negative digit borrows from QM instead
    // of propagating a carry through Q.
    always_comb begin
        q_nxt  = {q[W-2:0], 1'b0};
        qm_nxt = {qm[W-2:0], 1'b1};
        unique case (1'b1)
            pos: begin
                q_nxt  = {q[W-2:0], 1'b1};
                qm_nxt = {q[W-2:0], 1'b0};
            end
            neg: begin
                q_nxt  = {qm[W-2:0], 1'b1};
                qm_nxt = {qm[W-2:0], 1'b0};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sd_otf_converter.sv
// MSD-first signed-digit stream to two's-complement converter.
// Ports: start/din_valid/zp/zn in; busy, done, out_valid, q_out out.
module sd_otf_converter
    import sd_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         din_valid,
    input  logic         zp,
    input  logic         zn,
    output logic         busy,
    output logic         done,
    output logic         out_valid,
    output logic [N:0]   q_out
);

    localparam int W  = N + 1;
    localparam int CW = $clog2(N + 1);

    otf_state_t     state;
    otf_state_t     state_nxt;
    logic [W-1:0]   q;
    logic [W-1:0]   qm;
    logic [W-1:0]   q_step;
    logic [W-1:0]   qm_step;
    logic [CW-1:0]  cnt;
    logic           done_r;
    logic           ov_r;
    sd_digit_t      dig;
    logic           accept;
    logic           last;

    assign dig    = {zp, zn};
    // start has priority: a digit in the start cycle is dropped.
    assign accept = (state == CONV) && din_valid && !start;
    assign last   = (cnt == CW'(N - 1));

    sd_otf_step #(
        .W (W)
    ) u_step (
        .q      (q),
        .qm     (qm),
        .d      (dig),
        .q_nxt  (q_step),
        .qm_nxt (qm_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (1'b1)
            start:          state_nxt = CONV;
            accept && last: state_nxt = DONE;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q      <= '0;
            qm     <= '1;
            cnt    <= '0;
            done_r <= 1'b0;
            ov_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (start) begin
                q    <= '0;
                qm   <= '1;
                cnt  <= '0;
                ov_r <= 1'b0;
            end else if (accept) begin
                q   <= q_step;
                qm  <= qm_step;
                cnt <= cnt + CW'(1);
                if (last) begin
                    done_r <= 1'b1;
                    ov_r   <= 1'b1;
                end
            end
        end
    end

    assign busy      = (state == CONV);
    assign done      = done_r;
    assign out_valid = ov_r;
    assign q_out     = q;

endmodule

// File: tb/tb_sd_otf_converter.sv
// Scoreboard bench for sd_otf_converter at N = 4, 8 and 16.
// Expected words are pushed at stimulus time, popped on done.
module tb_sd_otf_converter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  st;
    logic [2:0]  dv;
    logic [2:0]  zp;
    logic [2:0]  zn;
    wire  [2:0]  busy;
    wire  [2:0]  done;
    wire  [2:0]  ov;
    wire  [4:0]  q4;
    wire  [8:0]  q8;
    wire  [16:0] q16;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int nw[3] = '{4, 8, 16};
    int done_cnt[3] = '{0, 0, 0};
    int last_done_cyc[3] = '{0, 0, 0};
    int e0[$];
    int e1[$];
    int e2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sd_otf_converter #(.N(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .din_valid(dv[0]),
        .zp(zp[0]), .zn(zn[0]), .busy(busy[0]), .done(done[0]),
        .out_valid(ov[0]), .q_out(q4)
    );

    sd_otf_converter #(.N(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .din_valid(dv[1]),
        .zp(zp[1]), .zn(zn[1]), .busy(busy[1]), .done(done[1]),
        .out_valid(ov[1]), .q_out(q8)
    );

    sd_otf_converter #(.N(16)) u16 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .din_valid(dv[2]),
        .zp(zp[2]), .zn(zn[2]), .busy(busy[2]), .done(done[2]),
        .out_valid(ov[2]), .q_out(q16)
    );

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic int getq(input int k);
        case (k)
            0:       return int'($signed(q4));
            1:       return int'($signed(q8));
            default: return int'($signed(q16));
        endcase
    endfunction

    function automatic void push(input int k, input int v);
        case (k)
            0:       e0.push_back(v);
            1:       e1.push_back(v);
            default: e2.push_back(v);
        endcase
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0:       return e0.size();
            1:       return e1.size();
            default: return e2.size();
        endcase
    endfunction

    function automatic int pop(input int k);
        case (k)
            0:       return e0.pop_front();
            1:       return e1.pop_front();
            default: return e2.pop_front();
        endcase
    endfunction

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_n && busy[1]) begin
                check("qm_inv8", int'(u8.qm), int'(9'(u8.q - 9'd1)));
            end
            for (int k = 0; k < 3; k++) begin
                if (done[k]) begin
                    done_cnt[k]++;
                    last_done_cyc[k] = cyc;
                    check("done_ov", int'(ov[k]), 1);
                    if (qsize(k) == 0) begin
                        check("unexpected_done", int'(done[k]), 0);
                    end else begin
                        check("q_out", getq(k), pop(k));
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic conv(input int k, input logic [1:0] codes[],
                        input int maxgap, input int pre);
        int exp;
        int dc0;
        int s_cyc;
        int nd;
        nd = codes.size();
        exp = 0;
        for (int i = 0; i < nd; i++) begin
            exp = exp * 2 + int'(codes[i][1]) - int'(codes[i][0]);
        end
        dc0 = done_cnt[k];
        if (pre > 0) begin
            st[k] = 1'b1;
            step();
            st[k] = 1'b0;
            for (int i = 0; i < pre; i++) begin
                dv[k] = 1'b1; zp[k] = 1'b1; zn[k] = 1'b0;
                step();
            end
            dv[k] = 1'b0;
        end
        push(k, exp);
        // a +1 digit alongside start must be dropped
        st[k] = 1'b1; dv[k] = 1'b1; zp[k] = 1'b1; zn[k] = 1'b0;
        s_cyc = cyc;
        step();
        st[k] = 1'b0; dv[k] = 1'b0;
        for (int i = 0; i < nd; i++) begin
            repeat ($urandom_range(0, maxgap)) step();
            if (i == nd - 1) check("early_done", done_cnt[k], dc0);
            dv[k] = 1'b1; zp[k] = codes[i][1]; zn[k] = codes[i][0];
            step();
            dv[k] = 1'b0;
        end
        for (int t = 0; t < 6 && done_cnt[k] == dc0; t++) begin
            @(negedge clk);
            #1;
        end
        if (done_cnt[k] == dc0) check("done_timeout", done_cnt[k], dc0 + 1);
        if (maxgap == 0) check("latency", last_done_cyc[k] - s_cyc, nw[k] + 1);
        step();
        step();
        check("done_once", done_cnt[k], dc0 + 1);
        check("busy_low", int'(busy[k]), 0);
    endtask

    initial begin
        logic [1:0] c[];
        int v;
        st = '0; dv = '0; zp = '0; zn = '0;
        fork
            monitor();
        join_none
        repeat (3) step();
        check("rst_busy", int'(busy[1]), 0);
        check("rst_done", int'(done[1]), 0);
        check("rst_ov", int'(ov[1]), 0);
        check("rst_q", getq(1), 0);
        rst_n = 1'b1;
        step();

        c = new[8];
        foreach (c[i]) c[i] = 2'b10;
        conv(1, c, 0, 0);
        check("pos_final", getq(1), 255);

        foreach (c[i]) c[i] = 2'b01;
        conv(1, c, 0, 0);
        check("neg_final", getq(1), -255);

        foreach (c[i]) c[i] = (i % 2 == 0) ? 2'b10 : 2'b01;
        conv(1, c, 3, 0);
        check("alt_final", getq(1), 85);

        foreach (c[i]) c[i] = (i % 2 == 0) ? 2'b11 : 2'b00;
        c[7] = 2'b10;
        conv(1, c, 3, 0);
        check("zero_enc", getq(1), 1);

        for (int i = 0; i < 3; i++) begin
            dv[1] = 1'b1; zp[1] = 1'b0; zn[1] = 1'b1;
            step();
        end
        dv[1] = 1'b0;
        check("hold_q", getq(1), 1);
        check("hold_ov", int'(ov[1]), 1);

        foreach (c[i]) c[i] = 2'b10;
        conv(1, c, 0, 3);
        check("abort_final", getq(1), 255);

        st[1] = 1'b1;
        step();
        st[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dv[1] = 1'b1; zp[1] = 1'b1; zn[1] = 1'b0;
            step();
        end
        dv[1] = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", int'(busy[1]), 0);
        check("arst_ov", int'(ov[1]), 0);
        check("arst_q", getq(1), 0);
        step();
        rst_n = 1'b1;
        step();
        foreach (c[i]) c[i] = 2'b00;
        conv(1, c, 1, 0);
        check("zeros_final", getq(1), 0);

        for (int k = 0; k < 3; k++) begin
            c = new[nw[k]];
            foreach (c[i]) c[i] = 2'b10;
            conv(k, c, 0, 0);
            check("max_pos", getq(k), (1 << nw[k]) - 1);
            foreach (c[i]) c[i] = 2'b01;
            conv(k, c, 1, 0);
            check("max_neg", getq(k), 1 - (1 << nw[k]));
            for (int r = 0; r < 12; r++) begin
                foreach (c[i]) begin
                    v = $urandom_range(0, 3);
                    c[i] = 2'(v);
                end
                conv(k, c, 2, 0);
            end
        end

        repeat (4) step();
        check("sb_drain", qsize(0) + qsize(1) + qsize(2), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
